// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_fifo
//
// Elastic sample buffer in the link_clk domain, placed directly in front of
// the JESD204 TPL DAC core. DMA beats arrive on an AXI-Stream slave. They are
// held until the buffer reaches PREFILL_LEVEL beats. After that the TPL pops
// one beat per request. The buffer empties itself whenever the TPL clears all
// channel enables.
//
// Ports:
//   clk           link_clk; every register updates on the rising edge
//   resetn        synchronous active-low reset
//   s_axis_valid  DMA beat valid
//   s_axis_ready  the block can take a beat (registered state only)
//   s_axis_data   DMA beat, DATA_WIDTH bits
//   enable        TPL channel enables; when none is set, the buffer flushes
//   dac_valid     TPL per-channel read request; the request is the OR of bits
//   dac_ddata     sample beat to the TPL, one cycle after the request
//   dac_dunf      one-cycle underflow flag, raised only while serving (RUN)
//   fifo_level    current occupancy, 0..2**ADDR_WIDTH
//
// Build option:
//   AD_IP_JESD204_TPL_DAC_FIFO_UNF_HOLD_EN - when defined, an underflow keeps
//   the last dac_ddata value instead of loading zero. dac_dunf is still
//   raised. When undefined, an underflow loads zero.
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_fifo #(
    parameter int NUM_CHANNELS  = 2,
    parameter int DATA_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 5,
    parameter int PREFILL_LEVEL = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    input  logic [NUM_CHANNELS-1:0] enable,
    input  logic [NUM_CHANNELS-1:0] dac_valid,
    output logic [DATA_WIDTH-1:0]   dac_ddata,
    output logic                    dac_dunf,
    output logic [ADDR_WIDTH:0]     fifo_level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PREFILL_L = (ADDR_WIDTH + 1)'(PREFILL_LEVEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    any_enable;
    logic                    request;
    logic                    wr;
    logic                    rd;
    logic                    mem_we;
    logic [ADDR_WIDTH:0]     level_next;

    assign any_enable = |enable;
    assign request    = |dac_valid;

    // Ready depends only on registered state. A read in the same cycle at
    // full does not open a slot.
    assign s_axis_ready = (state != IDLE) && (fifo_level != DEPTH_L);
    assign wr           = s_axis_valid && s_axis_ready;
    assign rd           = (state == RUN) && request && (fifo_level != '0);

    // A beat that is handshaked while reset is asserted or the buffer is
    // flushing must not touch storage.
    assign mem_we = wr && resetn && any_enable;

    always_comb begin
        level_next = fifo_level;
        if (wr && !rd) begin
            level_next = fifo_level + 1'b1;
        end else if (rd && !wr) begin
            level_next = fifo_level - 1'b1;
        end
    end

    // The sample storage has no reset. Stale contents can never be read,
    // because the pointers and the level are cleared together.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= s_axis_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            dac_ddata  <= '0;
            dac_dunf   <= 1'b0;
        end else if (!any_enable) begin
            // Flush in one cycle, whatever the current state.
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            dac_ddata  <= '0;
            dac_dunf   <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            fifo_level <= level_next;

            case (state)
                IDLE: begin
                    state     <= PREFILL;
                    dac_ddata <= '0;
                    dac_dunf  <= 1'b0;
                end

                PREFILL: begin
                    // Requests are answered with zero data and are not
                    // treated as underflow.
                    dac_ddata <= '0;
                    dac_dunf  <= 1'b0;
                    if (level_next >= PREFILL_L) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (rd) begin
                        dac_ddata <= mem[rd_ptr];
                        dac_dunf  <= 1'b0;
                        rd_ptr    <= rd_ptr + 1'b1;
                    end else if (request) begin
                        // An empty read. A beat written in this same cycle
                        // is not visible yet.
`ifdef AD_IP_JESD204_TPL_DAC_FIFO_UNF_HOLD_EN
                        dac_ddata <= dac_ddata;
`else
                        dac_ddata <= '0;
`endif
                        dac_dunf  <= 1'b1;
                    end else begin
                        dac_dunf  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_fifo.md
Name: ad_ip_jesd204_tpl_dac_fifo

Overview:
- Elastic sample buffer sitting directly upstream of the JESD204 TPL DAC core, in the link_clk domain.
- Accepts DMA sample beats on an AXI-Stream slave and serves them to the TPL on its per-beat request (`dac_valid`), returning `dac_ddata` and `dac_dunf`.
- Pre-fills to a programmable watermark before serving, absorbing DMA latency jitter.
- Flushes whenever the TPL deasserts all channel enables.

Parameters:
- NUM_CHANNELS, 2, channel count; width of `enable` and `dac_valid`.
- DATA_WIDTH, 128, beat width; equals TPL DMA data width (NUM_LANES*8*OCTETS_PER_BEAT).
- ADDR_WIDTH, 5, log2 storage depth; DEPTH = 2**ADDR_WIDTH beats.
- PREFILL_LEVEL, 16, occupancy required to leave PREFILL; legal range 1..DEPTH.

Ports:
- clk  in  1  link_clk; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- s_axis_valid  in  1  DMA beat valid.
- s_axis_ready  out  1  block can accept beat.
- s_axis_data  in  DATA_WIDTH  DMA beat.
- enable  in  NUM_CHANNELS  channel enables from TPL.
- dac_valid  in  NUM_CHANNELS  per-channel read request from TPL; request = OR of bits.
- dac_ddata  out  DATA_WIDTH  sample beat to TPL.
- dac_dunf  out  1  underflow flag to TPL.
- fifo_level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn=0 at an edge):
  - state=IDLE; wr_ptr, rd_ptr and fifo_level = 0.
  - dac_ddata=0, dac_dunf=0, s_axis_ready=0.
  - Reset mid-transfer discards stored data; the beat presented that cycle is not accepted.
- Storage:
  - Dual-pointer RAM of DEPTH x DATA_WIDTH.
  - Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0.
  - fifo_level is a registered counter: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Write:
  - s_axis_ready = (state != IDLE) && (fifo_level != DEPTH). Combinational from registers only; no dependence on s_axis_valid.
  - Beat is written when s_axis_valid && s_axis_ready.
  - No pass-through at full: a read in the same cycle does not open ready.
- State machine:
  - IDLE:
    - Pointers and level held at 0; dac_ddata=0; requests ignored; dac_dunf=0.
    - -> PREFILL when |enable=1.
  - PREFILL:
    - Writes accepted; requests return dac_ddata=0 and do not pop.
    - dac_dunf=0 (prefill is not underflow).
    - -> RUN at the edge where fifo_level (post-update) >= PREFILL_LEVEL.
  - RUN:
    - Request with fifo_level>0: pop head; dac_ddata <= head at that edge, giving 1-cycle latency from request to data.
    - Request with fifo_level==0: no pop; dac_ddata <= 0; dac_dunf <= 1 for one cycle.
    - No request: dac_ddata holds; dac_dunf <= 0.
    - Underflow does not leave RUN. Data resumes on the next request after a write lands.
  - Any state -> IDLE at the edge where |enable=0.
    - Flush in one cycle: pointers and level to 0, dac_ddata <= 0, dac_dunf <= 0.
    - A write attempted in that cycle is dropped: ready is already based on state, and state becomes IDLE.
- Simultaneous events:
  - Write and read at level 0: the written beat is not visible the same cycle; the read underflows and level becomes 1.
  - Write and read at level DEPTH: cannot occur, because ready=0 at full.
- dac_dunf is registered and asserted only in RUN.

Optional Feature:
- Macro: AD_IP_JESD204_TPL_DAC_FIFO_UNF_HOLD_EN.
- Defined: on underflow dac_ddata holds its previous value instead of loading 0; dac_dunf is still asserted. Held value is lost on IDLE flush (0).
- Undefined: underflow loads dac_ddata=0 as specified above.

Test Plan:
- Reset then enable=2'b01, PREFILL_LEVEL=16:
  - Push 15 beats, requests active -> dac_ddata=0, dac_dunf=0, state PREFILL, fifo_level=15.
  - 16th beat -> RUN next edge.
- RUN ordering: write beats 0x..01..0x..20 (32), continuous requests:
  - dac_ddata sequence 0x01..0x20 in order, one cycle after each request; wrap at DEPTH=32 seamless.
  - s_axis_ready=0 exactly when fifo_level=32.
- Underflow: stop DMA in RUN, drain to 0, one more request:
  - dac_ddata=0 and dac_dunf=1 for exactly one cycle.
  - With UNF_HOLD_EN defined: dac_ddata holds last beat, dac_dunf=1.
- Simultaneous read/write at level 0 -> dac_dunf=1, fifo_level=1; next request returns the written beat.
- Enable drop mid-stream at level 20 -> next edge: fifo_level=0, s_axis_ready=0, dac_ddata=0. Re-enable -> PREFILL, first served beat is the first beat written after re-enable.
- resetn=0 for one cycle at level 10 in RUN -> all outputs return to reset values next edge; s_axis_valid beat in that cycle not accepted.
